// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: round-robin two-requester front end running one AXI-Lite transaction at a time.
// Define AXIL_ARB_TIMEOUT_EN to add a watchdog that forces an SLVERR completion after TIMEOUT_CYCLES.
module axil_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXIL_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_resp,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_resp,
    output logic              busy,
    output logic              gnt_id,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
    state_t            state_q, state_d;
    logic              last_q, gnt_q, we_q, busy_q, sel_d, to, fin, to_hit;
    logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q, done0_q, done1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q, fin_rdata;
    logic [1:0]        resp0_q, resp1_q, fin_resp;
`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    always_comb begin
        sel_d = (m0_req && m1_req) ? !last_q : m1_req;
`ifdef AXIL_ARB_TIMEOUT_EN
        to = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
        to = 1'b0;
`endif
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !(m0_req || m1_req) ? IDLE : (sel_d ? m1_we : m0_we) ? WR : RD_ADDR;
            WR:      state_d = ((!awvalid_q || awready) && (!wvalid_q || wready)) ? WR_RESP : to ? DONE : WR;
            WR_RESP: state_d = (bvalid || to) ? DONE : WR_RESP;
            RD_ADDR: state_d = arready ? RD_DATA : to ? DONE : RD_ADDR;
            RD_DATA: state_d = (rvalid || to) ? DONE : RD_DATA;
            default: state_d = IDLE;
        endcase
        fin = state_q != DONE && state_d == DONE;
        // a finish without the slave's response means the watchdog fired
        to_hit = fin && !(state_q == WR_RESP && bvalid) && !(state_q == RD_DATA && rvalid);
        fin_resp = to_hit ? 2'b10 : (state_q == WR_RESP) ? bresp : rresp;
        fin_rdata = to_hit ? '0 : rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            resp0_q   <= '0;
            resp1_q   <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= state_d != IDLE;
            // each write valid rises on grant and falls at its own handshake
            awvalid_q <= state_d == WR && (state_q == IDLE || (awvalid_q && !awready));
            wvalid_q  <= state_d == WR && (state_q == IDLE || (wvalid_q && !wready));
            arvalid_q <= state_d == RD_ADDR;
            bready_q  <= state_d == WR_RESP;
            rready_q  <= state_d == RD_DATA;
            done0_q   <= fin && !gnt_q;
            done1_q   <= fin && gnt_q;
            if (state_q == IDLE && state_d != IDLE) begin
                gnt_q   <= sel_d;
                last_q  <= sel_d;
                we_q    <= sel_d ? m1_we : m0_we;
                addr_q  <= sel_d ? m1_addr : m0_addr;
                wdata_q <= sel_d ? m1_wdata : m0_wdata;
            end
            if (fin && !gnt_q) begin
                resp0_q <= fin_resp;
                if (!we_q || to_hit) rdata0_q <= fin_rdata;
            end
            if (fin && gnt_q) begin
                resp1_q <= fin_resp;
                if (!we_q || to_hit) rdata1_q <= fin_rdata;
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q <= (state_d != state_q || state_q == IDLE || state_q == DONE) ? '0 : cnt_q + 1'b1;
`endif
        end
    end

    assign busy     = busy_q;
    assign gnt_id   = gnt_q;
    assign awaddr   = addr_q;
    assign araddr   = addr_q;
    assign wdata    = wdata_q;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign arvalid  = arvalid_q;
    assign bready   = bready_q;
    assign rready   = rready_q;
    assign m0_done  = done0_q;
    assign m1_done  = done1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign m0_resp  = resp0_q;
    assign m1_resp  = resp1_q;
endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb_axil_master_arbiter: vector table and scoreboard bench for the arbiter against a 4-register slave model.
`timescale 1ns/1ps
module tb_axil_master_arbiter;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic m0_done, m1_done, busy, gnt_id;
    logic [31:0] m0_rdata, m1_rdata, awaddr, wdata, araddr, rdata;
    logic [1:0] m0_resp, m1_resp, bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

    axil_master_arbiter #(
        .ADDR_W(32),
`ifdef AXIL_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .DATA_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .busy(busy), .gnt_id(gnt_id),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    wire any_out = |{awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
                     m0_done, m0_rdata, m0_resp, m1_done, m1_rdata, m1_resp, busy, gnt_id};

    // slave model: 4 registers at 0x0..0xC, SLVERR beyond
    logic stall = 1'b0, aw_block = 1'b0, b_hold = 1'b0, aw_got, w_got;
    logic [31:0] mem [4] = '{default: 32'h0};
    wire aw_hs = awvalid && awready;
    wire w_hs = wvalid && wready;
    wire aw_in = awaddr < 32'h10;
    wire ar_in = araddr < 32'h10;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
        end else begin
            awready <= !aw_block && (!stall || $urandom_range(0, 1) == 1);
            wready  <= !stall || $urandom_range(0, 1) == 1;
            arready <= !stall || $urandom_range(0, 1) == 1;
            if (w_hs && aw_in) mem[awaddr[3:2]] <= wdata;
            if (bvalid && bready) bvalid <= 1'b0;
            else if ((aw_got || aw_hs) && (w_got || w_hs) && !b_hold && !bvalid) begin
                bvalid <= 1'b1;
                bresp <= aw_in ? 2'b00 : 2'b10;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
            if (aw_block) begin
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata <= ar_in ? mem[araddr[3:2]] : 32'h0;
                rresp <= ar_in ? 2'b00 : 2'b10;
            end
        end
    end

    typedef struct { logic id; logic chk_rd; logic [31:0] rdata; logic [1:0] resp; } exp_t;
    typedef struct { logic id; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic [1:0] resp; logic stall; } vec_t;
    exp_t sb[$];
    exp_t mon_e;
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic id, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (id) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
        else begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic expect_done(input logic id, input logic chk_rd, input logic [31:0] rd, input logic [1:0] rs);
        sb.push_back('{id, chk_rd, rd, rs});
    endtask

    task automatic wait_done(input logic id, input int maxc, output int cyc);
        cyc = 0;
        while (!(id ? m1_done : m0_done) && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        if (!(id ? m1_done : m0_done)) begin
            total++;
            bad++;
            $display("FAIL wait_done m%0d: no done after %0d cycles", id, maxc);
        end
        if (id) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    logic aw_prev = 1'b0;
    logic [31:0] aw_ref = '0;
    always @(negedge clk) begin
        if (m0_done || m1_done) begin
            chk("done_excl", 32'(m0_done && m1_done), 32'h0);
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'h1);
            else begin
                mon_e = sb.pop_front();
                chk("done_id", 32'(m1_done), 32'(mon_e.id));
                chk("gnt_id", 32'(gnt_id), 32'(mon_e.id));
                chk("resp", 32'(m1_done ? m1_resp : m0_resp), 32'(mon_e.resp));
                if (mon_e.chk_rd) chk("rdata", m1_done ? m1_rdata : m0_rdata, mon_e.rdata);
            end
        end
        if (awvalid && !aw_prev) aw_ref = awaddr;
        else if (awvalid || wvalid || bready) chk("awaddr_stable", awaddr, aw_ref);
        aw_prev = awvalid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n0, n1;
        logic md;
        vec_t v[10];
        v[0] = '{1'b0, 1'b1, 32'h4,  32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
        v[1] = '{1'b0, 1'b0, 32'h4,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0};
        v[2] = '{1'b1, 1'b1, 32'hC,  32'hCAFEF00D, 32'h0,        2'b00, 1'b1};
        v[3] = '{1'b1, 1'b0, 32'hC,  32'h0,        32'hCAFEF00D, 2'b00, 1'b1};
        v[4] = '{1'b0, 1'b0, 32'h0,  32'h0,        32'h11,       2'b00, 1'b0};
        v[5] = '{1'b1, 1'b0, 32'h8,  32'h0,        32'h22,       2'b00, 1'b1};
        v[6] = '{1'b0, 1'b1, 32'h8,  32'h12345678, 32'h0,        2'b00, 1'b1};
        v[7] = '{1'b1, 1'b0, 32'h8,  32'h0,        32'h12345678, 2'b00, 1'b0};
        v[8] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h0,        2'b10, 1'b0};
        v[9] = '{1'b1, 1'b1, 32'h14, 32'h5,        32'h0,        2'b10, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'(any_out), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 1'b0, 32'hC, 32'h0);
        expect_done(1'b1, 1'b1, 32'h0, 2'b00);
        wait_done(1'b1, 20, cyc);
        chk("m0_untouched", 32'(|{m0_done, m0_rdata, m0_resp}), 32'h0);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'h0);

        issue(1'b0, 1'b1, 32'h0, 32'h11);
        issue(1'b1, 1'b1, 32'h8, 32'h22);
        expect_done(1'b0, 1'b0, 32'h0, 2'b00);
        expect_done(1'b1, 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        chk("tie_busy", 32'(busy), 32'h1);
        chk("tie_gnt", 32'(gnt_id), 32'h0);
        wait_done(1'b0, 20, cyc);
        wait_done(1'b1, 20, cyc);
        @(negedge clk);

        foreach (v[i]) begin
            stall = v[i].stall;
            issue(v[i].id, v[i].we, v[i].addr, v[i].wdata);
            expect_done(v[i].id, !v[i].we, v[i].rdata, v[i].resp);
            wait_done(v[i].id, 80, cyc);
            if (!v[i].stall) chk("latency", 32'(cyc), 32'h3);
            @(negedge clk);
        end
        stall = 1'b0;

        issue(1'b0, 1'b0, 32'h4, 32'h0);
        issue(1'b1, 1'b0, 32'hC, 32'h0);
        for (int k = 0; k < 8; k++)
            expect_done(k[0], 1'b1, k[0] ? 32'hCAFEF00D : 32'hDEADBEEF, 2'b00);
        n0 = 0; n1 = 0; cyc = 0;
        while ((n0 < 4 || n1 < 4) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m0_done) begin n0++; if (n0 == 4) m0_req = 1'b0; end
            if (m1_done) begin n1++; if (n1 == 4) m1_req = 1'b0; end
        end
        chk("fair_n0", 32'(n0), 32'h4);
        chk("fair_n1", 32'(n1), 32'h4);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);

        b_hold = 1'b1;
        issue(1'b1, 1'b1, 32'hC, 32'h55);
        cyc = 0;
        while (!bready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("reach_wr_resp", 32'(bready), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_outs", 32'(any_out), 32'h0);
        m1_req = 1'b0;
        sb.delete();
        b_hold = 1'b0;
        md = 1'b0;
        repeat (2) begin @(negedge clk); md |= m1_done; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); md |= m1_done | busy; end
        chk("no_done_after_rst", 32'(md), 32'h0);

        issue(1'b0, 1'b0, 32'h4, 32'h0);
        issue(1'b1, 1'b0, 32'h8, 32'h0);
        expect_done(1'b0, 1'b1, 32'hDEADBEEF, 2'b00);
        expect_done(1'b1, 1'b1, 32'h12345678, 2'b00);
        @(negedge clk);
        chk("rst_tie_gnt", 32'(gnt_id), 32'h0);
        wait_done(1'b0, 20, cyc);
        wait_done(1'b1, 20, cyc);
        @(negedge clk);

`ifdef AXIL_ARB_TIMEOUT_EN
        aw_block = 1'b1;
        issue(1'b0, 1'b1, 32'h0, 32'hAB);
        expect_done(1'b0, 1'b1, 32'h0, 2'b10);
        wait_done(1'b0, 40, cyc);
        chk("tmo_latency", 32'(cyc), 32'd17);
        chk("tmo_valids", 32'({awvalid, wvalid}), 32'h0);
        aw_block = 1'b0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h8, 32'h0);
        expect_done(1'b1, 1'b1, 32'h12345678, 2'b00);
        wait_done(1'b1, 20, cyc);
        chk("post_tmo_latency", 32'(cyc), 32'h3);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Two-requester AXI-Lite master front end that shares one 4-register AXI-Lite slave (32-bit regs at byte offsets 0x0/0x4/0x8/0xC) between firmware-side and engine-side requesters.
- Accepts a simple req/done command per requester, arbitrates round-robin, runs exactly one AXI-Lite write or read at a time, and returns response and read data to the granted requester.

Parameters:
- ADDR_W, 32, address width on requester and AXI ports.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with AXIL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  command pending; held with command fields until matching done.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  byte address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DATA_W  read data; valid with done; holds until that requester's next done.
- m0_resp / m1_resp  out  2  BRESP/RRESP; valid with done.
- busy  out  1  transaction in flight (state != IDLE).
- gnt_id  out  1  requester owning the current or last transaction.
- awaddr, awvalid, awready, wdata, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready: standard AXI-Lite master side. Widths: ADDR_W/DATA_W/2/1 as usual. Ready/resp/data from the slave are inputs; the rest are outputs.

Behaviour:
- Reset (async assert): state=IDLE; all outputs 0, including valids, readies, done, rdata, resp, busy and gnt_id; last_grant=1, so m0 wins the first tie. Reset mid-transaction abandons it with no done.
- All outputs are registered. AXI addr/wdata are latched at grant and held stable for the whole transaction; the slave samples awaddr at the W handshake.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE arbitration:
  - Only one req high -> grant it.
  - Both high -> grant !last_grant.
  - On grant: latch we/addr/wdata, set gnt_id and last_grant, busy=1.
  - Next state is WR (we=1) or RD_ADDR (we=0).
- WR:
  - awvalid and wvalid rise together.
  - Each drops independently at its own handshake edge (valid&&ready).
  - When both handshakes are done, even on the same edge, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp, drop bready, go to DONE.
- RD_ADDR: arvalid=1 until arready edge, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata/rresp, drop rready, go to DONE.
- DONE:
  - Exactly one cycle; granted requester's done=1, then IDLE.
  - Requester drops or changes req on the edge where it sees done. IDLE therefore arbitrates next cycle on fresh req values.
- Latency: requester to done is at most 3 cycles plus slave wait cycles.
- Valids never wait on ready (no combinational ready->valid path). Once asserted, a valid is held until its handshake.
- Requester-change rule: changes to a granted requester's fields mid-transaction are ignored (latched copy used). Deasserting req mid-transaction does not abort it; done still pulses.
- Fairness: a requester holding req continuously alternates with the other; neither gets two consecutive grants while the other is pending.
- Non-granted requester outputs hold their previous values.

Optional Feature:
- Macro AXIL_ARB_TIMEOUT_EN.
- Defined: a counter clears on every state entry and increments in WR, WR_RESP, RD_ADDR and RD_DATA. On reaching TIMEOUT_CYCLES:
  - drop all valids/readies;
  - return resp=2'b10 (SLVERR), rdata=0;
  - go to DONE.
  - This is a debug recovery path; the AXI rule is knowingly broken.
- Undefined: no counter; the arbiter waits indefinitely.

Test Plan:
- m0 write addr 0x4 data 0xDEADBEEF, then m0 read 0x4 -> m0_done pulses twice; read gives rdata=0xDEADBEEF, resp=0; awaddr stable 0x4 from awvalid rise to bvalid.
- m0 and m1 req rise on the same cycle after reset (m0 write 0x0=0x11, m1 write 0x8=0x22) -> m0 granted first, then m1; reads of 0x0/0x8 give 0x11/0x22.
- Both hold req for 4 back-to-back reads each -> gnt_id sequence 0,1,0,1,...; never the same id twice while the other is pending.
- m1 read 0xC after reset -> m1_rdata=0, m1_resp=0; m0 outputs unchanged.
- Reset asserted during WR_RESP of m1 write -> all outputs 0 immediately, no m1_done. After release, m0/m1 tie grants m0.
- With AXIL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, awready tied 0 -> after 16 cycles in WR: awvalid/wvalid=0, done pulses with resp=2'b10, rdata=0; next request proceeds normally.
